traffic_phase_sequencer: RTL and testbench
==========================================

Name: traffic_phase_sequencer

Overview:
Master phase controller for the four-approach intersection. It drives the timer's current-state input (phase) and a restart pulse (load), and consumes the timer's expiry pulse. It sequences GREEN -> AMBER -> next GREEN, skipping approaches with no sensed traffic. It also honours an emergency-vehicle override and produces the per-approach lamp outputs.

Parameters:
AMBER_CYC, 3, amber duration in clk cycles (>=1)
NUM_APP, 4, number of approaches; fixed at 4, phase encoded in 2 bits

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE
enable  input  1  run request; low -> orderly shutdown to all-red
expired  input  1  one-cycle pulse from timer: green time of current phase elapsed
sense  input  4  vehicle presence, bit i = approach i; level, sampled each cycle
emerg  input  1  emergency override request, level
emerg_dir  input  2  approach to be given priority while emerg=1
phase  output  2  current phase to timer (timer selects delay1..delay4 from this)
load  output  1  one-cycle pulse: timer restarts its count for phase
green  output  4  one-hot green lamp, bit = phase
yellow  output  4  one-hot amber lamp, bit = phase
red  output  4  red lamps = ~(green|yellow)

Behaviour:
- All outputs registered.
- Reset values: state=IDLE, phase=0, load=0, green=0, yellow=0, red=4'b1111, amber counter=0.
- States:
  - IDLE: all red.
  - GREEN: green[phase]=1.
  - AMBER: yellow[phase]=1.
- IDLE -> GREEN on the first clk edge with enable=1:
  - phase=0, or emerg_dir if emerg=1.
  - load=1 for exactly that first GREEN cycle.
- GREEN, normal:
  - Hold until expired=1.
  - Then AMBER next cycle, with amber counter loaded to AMBER_CYC-1.
  - expired is ignored in IDLE and AMBER.
- AMBER:
  - Counter decrements each cycle.
  - In the cycle the counter=0, select next phase and move to GREEN; phase and load=1 update on the same edge.
- Next-phase select, evaluated on the AMBER exit edge:
  - If emerg=1: next = emerg_dir.
  - Else: first of p+1, p+2, p+3 (mod 4) whose sense bit is 1.
  - If none are set: p+1 (mod 4). Default round-robin; the current approach is never re-granted without emergency.
- Emergency in GREEN, emerg_dir != phase: go to AMBER next cycle (early termination). Following green = emerg_dir.
- Emergency in GREEN, emerg_dir == phase:
  - Stay GREEN; ignore expired while emerg=1.
  - On the emerg 1->0 edge, pulse load once to restart full green time.
- emerg changing during AMBER: only the value at the AMBER exit edge matters. Amber time is never shortened.
- Shutdown:
  - enable=0 in GREEN -> AMBER next cycle.
  - When AMBER completes and enable=0 -> IDLE, no load.
  - enable re-asserted during that AMBER -> normal next-phase select.
- Simultaneous events in GREEN: expired=1 and emerg=1 with emerg_dir != phase -> single transition to AMBER, next = emerg_dir.
- Reset asserted mid-operation: immediate (asynchronous) return to all reset values. No amber is guaranteed; the timer is also reset by the same signal.
- Invariants, every cycle:
  - at most one bit of green|yellow set;
  - red == ~(green|yellow);
  - load never high in two consecutive cycles.

Decomposition:
- Shared package traffic_pkg:
  - state enum (IDLE, GREEN, AMBER);
  - phase width constant (2);
  - NUM_APP;
  - lamp encoding helper constant 4'b1111 for all-red.
- One natural sub-module: next_phase_arbiter. Combinational rotating priority arbiter; inputs current phase, sense, emerg, emerg_dir; output next phase. It keeps the FSM file small and is unit-testable alone.

Test Plan:
1. Round-robin, AMBER_CYC=3:
   - Stimulus: reset pulse; enable=1, sense=4'b1111; expired pulse after 5 cycles in each GREEN.
   - Response: phase sequence 0,1,2,3,0; load pulses once per GREEN entry; yellow high exactly 3 cycles per phase; red=~(green|yellow) throughout.
2. Skip empty approaches:
   - Stimulus: sense=4'b1001 while in phase 0; expired.
   - Response: next green is phase 3, then phase 0 again. With sense=0 the sequence is 0->1->2.
3. Emergency preemption:
   - Stimulus: in GREEN phase 1, set emerg=1, emerg_dir=3.
   - Response: next cycle AMBER on phase 1 for 3 cycles, then GREEN phase 3 with load.
   - Then hold emerg 20 cycles with expired pulses: stays green 3. Release emerg: one load pulse, then normal expiry.
4. Simultaneous events:
   - Stimulus: expired=1 and emerg=1, emerg_dir=2, in the same cycle in GREEN phase 0.
   - Response: single AMBER, then green 2; no double load.
5. Shutdown/restart:
   - Stimulus: enable=0 in GREEN phase 2.
   - Response: AMBER 3 cycles, then IDLE with red=4'b1111, no load; expired pulses in IDLE ignored.
   - Then enable=1: green 0 with load next edge.
6. Async reset mid-amber:
   - Stimulus: assert reset between clock edges during AMBER.
   - Response: outputs go to reset values before the next edge; after release with enable=1, sequence restarts at phase 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and constants for the intersection phase sequencer
//
// Purpose: common state encoding, phase width, approach count and lamp helpers
//          used by the sequencer FSM and its next-phase arbiter.
// Ports:   none (package)
package traffic_pkg;

  localparam int NUM_APP = 4;
  localparam int PHASE_W = 2;

  // Lamp pattern with every approach held at red.
  localparam logic [NUM_APP-1:0] ALL_RED = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GREEN = 2'd1,
    ST_AMBER = 2'd2
  } state_e;

  // One-hot lamp vector for a phase index.
  function automatic logic [NUM_APP-1:0] phase_onehot(input logic [PHASE_W-1:0] p);
    logic [NUM_APP-1:0] one;
    one = 4'b0001;
    return one << p;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_next_phase_arbiter.sv
// rtl/traffic_phase_sequencer_next_phase_arbiter.sv - rotating-priority next-phase selector
//
// Purpose: picks the approach that gets the next green. An emergency request
//          wins outright; otherwise the first approach after the current one
//          (in rotating order) with sensed traffic is chosen, falling back to
//          plain round-robin when nobody is waiting.
// Ports:
//   phase_i      current phase
//   sense_i      vehicle presence per approach
//   emerg_i      emergency override request
//   emerg_dir_i  approach requested by the emergency vehicle
//   next_phase_o selected next phase (combinational)
module next_phase_arbiter
  import traffic_pkg::*;
(
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [NUM_APP-1:0] sense_i,
  input  logic               emerg_i,
  input  logic [PHASE_W-1:0] emerg_dir_i,
  output logic [PHASE_W-1:0] next_phase_o
);

  logic [PHASE_W-1:0] p1;
  logic [PHASE_W-1:0] p2;
  logic [PHASE_W-1:0] p3;

  // Two-bit adds wrap naturally, giving the mod-4 rotation.
  assign p1 = phase_i + 2'd1;
  assign p2 = phase_i + 2'd2;
  assign p3 = phase_i + 2'd3;

  // The current approach is deliberately absent from the search so it is
  // never re-granted without an emergency.
  always_comb begin
    next_phase_o = p1;
    if (emerg_i) begin
      next_phase_o = emerg_dir_i;
    end else if (sense_i[p1]) begin
      next_phase_o = p1;
    end else if (sense_i[p2]) begin
      next_phase_o = p2;
    end else if (sense_i[p3]) begin
      next_phase_o = p3;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - master phase FSM for the four-approach intersection
//
// Purpose: sequences GREEN -> AMBER -> next GREEN, drives the timer's phase and
//          restart pulse, honours emergency preemption and orderly shutdown,
//          and produces registered lamp outputs.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset, forces IDLE / all red
//   enable     run request; low requests shutdown to all-red
//   expired    one-cycle pulse from timer: green time elapsed
//   sense      vehicle presence per approach (level)
//   emerg      emergency override request (level)
//   emerg_dir  approach given priority while emerg is high
//   phase      current phase to timer
//   load       one-cycle timer restart pulse
//   green      one-hot green lamps
//   yellow     one-hot amber lamps
//   red        red lamps, always ~(green|yellow)
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int AMBER_CYC = 3,
  parameter int NUM_APP   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               expired,
  input  logic [NUM_APP-1:0] sense,
  input  logic               emerg,
  input  logic [1:0]         emerg_dir,
  output logic [1:0]         phase,
  output logic               load,
  output logic [NUM_APP-1:0] green,
  output logic [NUM_APP-1:0] yellow,
  output logic [NUM_APP-1:0] red
);

  localparam int CNT_W = (AMBER_CYC > 1) ? $clog2(AMBER_CYC) : 1;
  localparam logic [CNT_W-1:0] AMBER_LOAD = CNT_W'(AMBER_CYC - 1);

  state_e             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic               load_q, load_d;
  logic [NUM_APP-1:0] green_q, green_d;
  logic [NUM_APP-1:0] yellow_q, yellow_d;
  logic [NUM_APP-1:0] red_q, red_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Set while an emergency is holding the already-green approach; its
  // falling edge triggers the full-green restart.
  logic               hold_q, hold_d;

  logic [1:0]         next_phase;

  next_phase_arbiter u_arb (
    .phase_i      (phase_q),
    .sense_i      (sense),
    .emerg_i      (emerg),
    .emerg_dir_i  (emerg_dir),
    .next_phase_o (next_phase)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    load_d  = 1'b0;
    cnt_d   = cnt_q;
    hold_d  = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_GREEN;
          phase_d = emerg ? emerg_dir : 2'd0;
          load_d  = 1'b1;
        end
      end

      ST_GREEN: begin
        // Preemption to another approach and shutdown both end the green
        // early; a coincident expiry collapses into the same single amber.
        if ((emerg && (emerg_dir != phase_q)) || !enable) begin
          state_d = ST_AMBER;
          cnt_d   = AMBER_LOAD;
          hold_d  = 1'b0;
        end else if (emerg) begin
          hold_d = 1'b1;
        end else if (hold_q) begin
          // Emergency just released on the green approach: give it a fresh
          // full green rather than whatever was left on the timer.
          hold_d = 1'b0;
          load_d = 1'b1;
        end else if (expired) begin
          state_d = ST_AMBER;
          cnt_d   = AMBER_LOAD;
        end
      end

      ST_AMBER: begin
        if (cnt_q == '0) begin
          hold_d = 1'b0;
          if (enable) begin
            state_d = ST_GREEN;
            phase_d = next_phase;
            load_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            phase_d = 2'd0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = 2'd0;
        cnt_d   = '0;
        hold_d  = 1'b0;
      end
    endcase

    // Lamps are decoded from the next state so they register together with it.
    green_d  = (state_d == ST_GREEN) ? phase_onehot(phase_d) : '0;
    yellow_d = (state_d == ST_AMBER) ? phase_onehot(phase_d) : '0;
    red_d    = ~(green_d | yellow_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      phase_q  <= 2'd0;
      load_q   <= 1'b0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= ALL_RED;
      cnt_q    <= '0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      load_q   <= load_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
    end
  end

  assign phase  = phase_q;
  assign load   = load_q;
  assign green  = green_q;
  assign yellow = yellow_q;
  assign red    = red_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - directed self-checking bench for traffic_phase_sequencer
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       expired;
  logic [3:0] sense;
  logic       emerg;
  logic [1:0] emerg_dir;
  logic [1:0] phase;
  logic       load;
  logic [3:0] green;
  logic [3:0] yellow;
  logic [3:0] red;

  int n_checks = 0;
  int n_fail   = 0;
  logic load_prev = 1'b0;

  traffic_phase_sequencer #(.AMBER_CYC(3), .NUM_APP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .expired   (expired),
    .sense     (sense),
    .emerg     (emerg),
    .emerg_dir (emerg_dir),
    .phase     (phase),
    .load      (load),
    .green     (green),
    .yellow    (yellow),
    .red       (red)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input logic [1:0] p);
    logic [3:0] one;
    one = 4'b0001;
    return one << p;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] g, input logic [3:0] y,
                           input logic [1:0] p, input logic l);
    check({tag, ".green"},  {4'h0, green},  {4'h0, g});
    check({tag, ".yellow"}, {4'h0, yellow}, {4'h0, y});
    check({tag, ".phase"},  {6'h0, phase},  {6'h0, p});
    check({tag, ".load"},   {7'h0, load},   {7'h0, l});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at the first green sample of ph; leaves at the first green sample of nxt.
  task automatic run_phase(input logic [1:0] ph, input logic [1:0] nxt);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("hold_green", oh(ph), 4'h0, ph, 1'b0);
    end
    expired = 1'b1;
    tick();
    expired = 1'b0;
    check_out("amber1", 4'h0, oh(ph), ph, 1'b0);
    tick();
    check_out("amber2", 4'h0, oh(ph), ph, 1'b0);
    tick();
    check_out("amber3", 4'h0, oh(ph), ph, 1'b0);
    tick();
    check_out("next_green", oh(nxt), 4'h0, nxt, 1'b1);
  endtask

  // Lamp and load invariants, sampled mid-cycle.
  always @(negedge clk) begin
    check("inv_red", {4'h0, red}, {4'h0, ~(green | yellow)});
    check("inv_onehot", {7'h0, $onehot0(green | yellow)}, 8'h01);
    check("inv_load_pair", {7'h0, load & load_prev}, 8'h00);
    load_prev = load;
  end

  initial begin
    reset = 1'b1; enable = 1'b0; expired = 1'b0; sense = 4'h0;
    emerg = 1'b0; emerg_dir = 2'd0;
    tick(); tick();
    check_out("reset", 4'h0, 4'h0, 2'd0, 1'b0);
    check("reset.red", {4'h0, red}, 8'h0f);
    reset = 1'b0;
    tick();
    check_out("idle_no_enable", 4'h0, 4'h0, 2'd0, 1'b0);

    // Round-robin with all approaches occupied.
    enable = 1'b1; sense = 4'b1111;
    tick();
    check_out("first_green", 4'b0001, 4'h0, 2'd0, 1'b1);
    run_phase(2'd0, 2'd1);
    run_phase(2'd1, 2'd2);
    run_phase(2'd2, 2'd3);
    run_phase(2'd3, 2'd0);

    // Skip empty approaches.
    sense = 4'b1001;
    run_phase(2'd0, 2'd3);
    run_phase(2'd3, 2'd0);
    sense = 4'b0000;
    run_phase(2'd0, 2'd1);

    // Emergency preemption from phase 1 to phase 3.
    tick();
    check_out("p1_green", 4'b0010, 4'h0, 2'd1, 1'b0);
    emerg = 1'b1; emerg_dir = 2'd3;
    tick();
    check_out("preempt_amber1", 4'h0, 4'b0010, 2'd1, 1'b0);
    tick();
    check_out("preempt_amber2", 4'h0, 4'b0010, 2'd1, 1'b0);
    tick();
    check_out("preempt_amber3", 4'h0, 4'b0010, 2'd1, 1'b0);
    tick();
    check_out("emerg_green", 4'b1000, 4'h0, 2'd3, 1'b1);
    for (int i = 0; i < 20; i++) begin
      expired = ((i % 5) == 4);
      tick();
      check_out("emerg_hold", 4'b1000, 4'h0, 2'd3, 1'b0);
    end
    expired = 1'b0; emerg = 1'b0;
    tick();
    check_out("emerg_release", 4'b1000, 4'h0, 2'd3, 1'b1);
    tick();
    check_out("after_release", 4'b1000, 4'h0, 2'd3, 1'b0);
    expired = 1'b1;
    tick();
    expired = 1'b0;
    check_out("post_emerg_amber", 4'h0, 4'b1000, 2'd3, 1'b0);
    tick(); tick(); tick();
    check_out("post_emerg_green", 4'b0001, 4'h0, 2'd0, 1'b1);

    // Simultaneous expiry and emergency in phase 0.
    tick();
    expired = 1'b1; emerg = 1'b1; emerg_dir = 2'd2;
    tick();
    expired = 1'b0;
    check_out("simul_amber1", 4'h0, 4'b0001, 2'd0, 1'b0);
    emerg_dir = 2'd1;
    tick();
    check_out("simul_amber2", 4'h0, 4'b0001, 2'd0, 1'b0);
    emerg_dir = 2'd2;
    tick();
    check_out("simul_amber3", 4'h0, 4'b0001, 2'd0, 1'b0);
    tick();
    check_out("simul_green", 4'b0100, 4'h0, 2'd2, 1'b1);
    emerg = 1'b0;
    tick();
    check_out("simul_no_double_load", 4'b0100, 4'h0, 2'd2, 1'b0);

    // Shutdown from phase 2, then restart.
    enable = 1'b0;
    tick();
    check_out("shut_amber1", 4'h0, 4'b0100, 2'd2, 1'b0);
    tick(); tick();
    check_out("shut_amber3", 4'h0, 4'b0100, 2'd2, 1'b0);
    tick();
    check_out("shut_idle", 4'h0, 4'h0, 2'd0, 1'b0);
    check("shut_idle.red", {4'h0, red}, 8'h0f);
    expired = 1'b1;
    tick();
    expired = 1'b0;
    check_out("idle_ignore_expired", 4'h0, 4'h0, 2'd0, 1'b0);
    tick();
    check_out("idle_stays", 4'h0, 4'h0, 2'd0, 1'b0);
    enable = 1'b1;
    tick();
    check_out("restart_green", 4'b0001, 4'h0, 2'd0, 1'b1);

    // Asynchronous reset in the middle of amber.
    tick();
    expired = 1'b1;
    tick();
    expired = 1'b0;
    check_out("pre_reset_amber", 4'h0, 4'b0001, 2'd0, 1'b0);
    tick();
    #2 reset = 1'b1;
    #1;
    check_out("async_reset", 4'h0, 4'h0, 2'd0, 1'b0);
    check("async_reset.red", {4'h0, red}, 8'h0f);
    tick();
    reset = 1'b0;
    check_out("reset_held", 4'h0, 4'h0, 2'd0, 1'b0);
    tick();
    check_out("post_reset_green", 4'b0001, 4'h0, 2'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
